// File: rtl/regfile_mp.sv
// Multi-port register file: two bypassed read ports, two write ports, load scoreboard and clear sweep.
// Define REGFILE_R0_ZERO_EN to hardwire register 0 to zero.
module regfile_mp #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we0,
    input  logic [ADDR_W-1:0] wa0,
    input  logic [DATA_W-1:0] wd0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] wa1,
    input  logic [DATA_W-1:0] wd1,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    output logic              busy1,
    output logic              busy2,
    input  logic              issue_v,
    input  logic [ADDR_W-1:0] issue_rd,
    input  logic              clear_req,
    output logic              clr_busy,
    output logic              wcollide
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

`ifdef REGFILE_R0_ZERO_EN
    localparam bit R0_ZERO = 1'b1;
`else
    localparam bit R0_ZERO = 1'b0;
`endif

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t            state_r;
    state_t            state_nxt_s;
    logic [ADDR_W-1:0] cnt_r;
    logic [DATA_W-1:0] rf_r [DEPTH];
    logic [DEPTH-1:0]  pend_r;
    logic              idle_s;
    logic              wr0_s;
    logic              wr1_s;
    logic              iss_s;
    logic              collide_s;
    logic              wcollide_r;
    logic              clr_busy_r;
    logic [DATA_W-1:0] rd1_s;
    logic [DATA_W-1:0] rd2_s;
    logic              busy1_s;
    logic              busy2_s;

    // An address is writable/trackable unless it is the hardwired zero register.
    function automatic logic addr_live(input logic [ADDR_W-1:0] a);
        return !(R0_ZERO && (a == {ADDR_W{1'b0}}));
    endfunction

    function automatic logic [DATA_W-1:0] read_mux(
        input logic [ADDR_W-1:0] ra,
        input logic [DATA_W-1:0] raw
    );
        logic [DATA_W-1:0] val;
        if (!addr_live(ra)) begin
            val = {DATA_W{1'b0}};
        end else if (wr0_s && (wa0 == ra)) begin
            val = wd0;
        end else if (wr1_s && (wa1 == ra)) begin
            val = wd1;
        end else begin
            val = raw;
        end
        return val;
    endfunction

    // A same-cycle write hides a pending bit unless the same cycle re-issues that register.
    function automatic logic busy_mux(input logic [ADDR_W-1:0] ra);
        logic hit_wr;
        logic hit_iss;
        hit_wr  = (wr0_s && (wa0 == ra)) || (wr1_s && (wa1 == ra));
        hit_iss = iss_s && (issue_rd == ra);
        return (hit_wr && !hit_iss) ? 1'b0 : pend_r[ra];
    endfunction

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic: sweep runs exactly DEPTH cycles.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE:    state_nxt_s = clear_req ? CLEAR : IDLE;
            CLEAR:   state_nxt_s = (cnt_r == LAST_ADDR) ? IDLE : CLEAR;
            default: state_nxt_s = IDLE;
        endcase
    end

    // Output/qualifier decode: writes and issues only take effect in IDLE.
    always_comb begin
        idle_s    = (state_r == IDLE);
        wr0_s     = we0 && idle_s && addr_live(wa0);
        wr1_s     = we1 && idle_s && addr_live(wa1);
        iss_s     = issue_v && idle_s && addr_live(issue_rd);
        collide_s = wr0_s && wr1_s && (wa0 == wa1);
        rd1_s     = read_mux(ra1, rf_r[ra1]);
        rd2_s     = read_mux(ra2, rf_r[ra2]);
        busy1_s   = busy_mux(ra1);
        busy2_s   = busy_mux(ra2);
    end

    // Sweep counter and registered status flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_r      <= {ADDR_W{1'b0}};
            wcollide_r <= 1'b0;
            clr_busy_r <= 1'b0;
        end else begin
            wcollide_r <= collide_s;
            clr_busy_r <= (state_nxt_s == CLEAR);
            if (state_r == CLEAR) begin
                cnt_r <= cnt_r + ADDR_W'(1);
            end else begin
                cnt_r <= {ADDR_W{1'b0}};
            end
        end
    end

    // Register array: sweep zeroing, otherwise port 1 then port 0 so port 0 wins a collision.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                rf_r[i] <= {DATA_W{1'b0}};
            end
        end else if (state_r == CLEAR) begin
            rf_r[cnt_r] <= {DATA_W{1'b0}};
        end else begin
            if (wr1_s && !collide_s) begin
                rf_r[wa1] <= wd1;
            end
            if (wr0_s) begin
                rf_r[wa0] <= wd0;
            end
        end
    end

    // Pending scoreboard: issue sets (and beats a write), writes clear, sweep entry wipes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_r <= {DEPTH{1'b0}};
        end else if (idle_s && clear_req) begin
            pend_r <= {DEPTH{1'b0}};
        end else if (idle_s) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (iss_s && (issue_rd == ADDR_W'(i))) begin
                    pend_r[i] <= 1'b1;
                end else if ((wr0_s && (wa0 == ADDR_W'(i))) || (wr1_s && (wa1 == ADDR_W'(i)))) begin
                    pend_r[i] <= 1'b0;
                end
            end
        end
    end

    assign rd1      = rd1_s;
    assign rd2      = rd2_s;
    assign busy1    = busy1_s;
    assign busy2    = busy2_s;
    assign clr_busy = clr_busy_r;
    assign wcollide = wcollide_r;

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: vector table with expectation queue, plus sweep/reset/r0 sequences.
module tb_regfile_mp;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        we0 = 1'b0, we1 = 1'b0, issue_v = 1'b0, clear_req = 1'b0;
    logic [2:0]  wa0 = 3'd0, wa1 = 3'd0, ra1 = 3'd0, ra2 = 3'd0, issue_rd = 3'd0;
    logic [15:0] wd0 = 16'd0, wd1 = 16'd0;
    logic [15:0] rd1, rd2;
    logic        busy1, busy2, clr_busy, wcollide;

    int n_tests = 0;
    int n_fail  = 0;

    regfile_mp #(.DATA_W(16), .ADDR_W(3)) dut (
        .clk(clk), .reset(reset),
        .we0(we0), .wa0(wa0), .wd0(wd0),
        .we1(we1), .wa1(wa1), .wd1(wd1),
        .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
        .busy1(busy1), .busy2(busy2),
        .issue_v(issue_v), .issue_rd(issue_rd),
        .clear_req(clear_req), .clr_busy(clr_busy), .wcollide(wcollide)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic we0; logic [2:0] wa0; logic [15:0] wd0;
        logic we1; logic [2:0] wa1; logic [15:0] wd1;
        logic [2:0] ra1; logic [2:0] ra2;
        logic iv; logic [2:0] ird;
        logic [15:0] e_rd1; logic [15:0] e_rd2;
        logic e_b1; logic e_b2; logic e_wc;
    } vec_t;

    typedef struct {
        int idx;
        logic [15:0] rd1; logic [15:0] rd2;
        logic b1; logic b2; logic wc;
    } exp_t;

    localparam int NV = 18;
    vec_t tbl [NV];
    exp_t expq [$];

    function automatic vec_t mk(
        input logic w0, input logic [2:0] a0, input logic [15:0] d0,
        input logic w1, input logic [2:0] a1, input logic [15:0] d1,
        input logic [2:0] r1, input logic [2:0] r2,
        input logic iv, input logic [2:0] ird,
        input logic [15:0] e1, input logic [15:0] e2,
        input logic b1, input logic b2, input logic wc);
        vec_t v;
        v.we0 = w0; v.wa0 = a0; v.wd0 = d0;
        v.we1 = w1; v.wa1 = a1; v.wd1 = d1;
        v.ra1 = r1; v.ra2 = r2; v.iv = iv; v.ird = ird;
        v.e_rd1 = e1; v.e_rd2 = e2; v.e_b1 = b1; v.e_b2 = b2; v.e_wc = wc;
        return v;
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic quiet();
        we0 = 1'b0; we1 = 1'b0; issue_v = 1'b0; clear_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        exp_t e;
        int   count;

        //        we0 wa0  wd0        we1 wa1  wd1        ra1   ra2   iv   ird   rd1        rd2        b1    b2    wc
        tbl[0]  = mk(1'b0,3'd0,16'h0000, 1'b0,3'd0,16'h0000, 3'd0,3'd7, 1'b0,3'd0, 16'h0000,16'h0000, 1'b0,1'b0,1'b0);
        tbl[1]  = mk(1'b1,3'd3,16'h1234, 1'b0,3'd0,16'h0000, 3'd1,3'd3, 1'b0,3'd0, 16'h0000,16'h1234, 1'b0,1'b0,1'b0);
        tbl[2]  = mk(1'b0,3'd0,16'h0000, 1'b0,3'd0,16'h0000, 3'd3,3'd3, 1'b0,3'd0, 16'h1234,16'h1234, 1'b0,1'b0,1'b0);
        tbl[3]  = mk(1'b1,3'd5,16'hAAAA, 1'b1,3'd5,16'h5555, 3'd5,3'd6, 1'b0,3'd0, 16'hAAAA,16'h0000, 1'b0,1'b0,1'b0);
        tbl[4]  = mk(1'b0,3'd0,16'h0000, 1'b0,3'd0,16'h0000, 3'd5,3'd3, 1'b0,3'd0, 16'hAAAA,16'h1234, 1'b0,1'b0,1'b1);
        tbl[5]  = mk(1'b0,3'd0,16'h0000, 1'b0,3'd0,16'h0000, 3'd5,3'd5, 1'b0,3'd0, 16'hAAAA,16'hAAAA, 1'b0,1'b0,1'b0);
        tbl[6]  = mk(1'b0,3'd0,16'h0000, 1'b1,3'd6,16'hBEEF, 3'd6,3'd6, 1'b0,3'd0, 16'hBEEF,16'hBEEF, 1'b0,1'b0,1'b0);
        tbl[7]  = mk(1'b1,3'd6,16'h1111, 1'b1,3'd7,16'h2222, 3'd6,3'd7, 1'b0,3'd0, 16'h1111,16'h2222, 1'b0,1'b0,1'b0);
        tbl[8]  = mk(1'b0,3'd0,16'h0000, 1'b0,3'd0,16'h0000, 3'd2,3'd2, 1'b1,3'd2, 16'h0000,16'h0000, 1'b0,1'b0,1'b0);
        tbl[9]  = mk(1'b0,3'd0,16'h0000, 1'b0,3'd0,16'h0000, 3'd2,3'd7, 1'b0,3'd0, 16'h0000,16'h2222, 1'b1,1'b0,1'b0);
        tbl[10] = mk(1'b0,3'd0,16'h0000, 1'b1,3'd2,16'h0042, 3'd2,3'd2, 1'b0,3'd0, 16'h0042,16'h0042, 1'b0,1'b0,1'b0);
        tbl[11] = mk(1'b0,3'd0,16'h0000, 1'b0,3'd0,16'h0000, 3'd2,3'd7, 1'b0,3'd0, 16'h0042,16'h2222, 1'b0,1'b0,1'b0);
        tbl[12] = mk(1'b1,3'd4,16'h4444, 1'b0,3'd0,16'h0000, 3'd4,3'd4, 1'b1,3'd4, 16'h4444,16'h4444, 1'b0,1'b0,1'b0);
        tbl[13] = mk(1'b0,3'd0,16'h0000, 1'b0,3'd0,16'h0000, 3'd4,3'd7, 1'b0,3'd0, 16'h4444,16'h2222, 1'b1,1'b0,1'b0);
        tbl[14] = mk(1'b0,3'd0,16'h0000, 1'b0,3'd0,16'h0000, 3'd6,3'd4, 1'b1,3'd6, 16'h1111,16'h4444, 1'b0,1'b1,1'b0);
        tbl[15] = mk(1'b1,3'd4,16'h0404, 1'b0,3'd0,16'h0000, 3'd4,3'd6, 1'b1,3'd4, 16'h0404,16'h1111, 1'b1,1'b1,1'b0);
        tbl[16] = mk(1'b0,3'd0,16'h0000, 1'b1,3'd4,16'h4141, 3'd4,3'd6, 1'b0,3'd0, 16'h4141,16'h1111, 1'b0,1'b1,1'b0);
        tbl[17] = mk(1'b0,3'd0,16'h0000, 1'b0,3'd0,16'h0000, 3'd4,3'd6, 1'b0,3'd0, 16'h4141,16'h1111, 1'b0,1'b1,1'b0);

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check("reset.clr_busy", {15'd0, clr_busy}, 16'd0);
        check("reset.wcollide", {15'd0, wcollide}, 16'd0);
        @(negedge clk);
        reset = 1'b0;

        // Vector table: expectations queued at drive, popped when outputs settle.
        for (int i = 0; i < NV; i++) begin
            @(posedge clk);
            #1;
            we0 = tbl[i].we0; wa0 = tbl[i].wa0; wd0 = tbl[i].wd0;
            we1 = tbl[i].we1; wa1 = tbl[i].wa1; wd1 = tbl[i].wd1;
            ra1 = tbl[i].ra1; ra2 = tbl[i].ra2;
            issue_v = tbl[i].iv; issue_rd = tbl[i].ird;
            expq.push_back('{i, tbl[i].e_rd1, tbl[i].e_rd2, tbl[i].e_b1, tbl[i].e_b2, tbl[i].e_wc});
            @(negedge clk);
            e = expq.pop_front();
            check($sformatf("v%0d.rd1", e.idx), rd1, e.rd1);
            check($sformatf("v%0d.rd2", e.idx), rd2, e.rd2);
            check($sformatf("v%0d.busy1", e.idx), {15'd0, busy1}, {15'd0, e.b1});
            check($sformatf("v%0d.busy2", e.idx), {15'd0, busy2}, {15'd0, e.b2});
            check($sformatf("v%0d.wcollide", e.idx), {15'd0, wcollide}, {15'd0, e.wc});
        end

        // Clear sweep: load every register, mark r3 pending, then sweep.
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            we0 = 1'b1; wa0 = 3'(2 * i);     wd0 = 16'h1000 + 16'(2 * i);
            we1 = 1'b1; wa1 = 3'(2 * i + 1); wd1 = 16'h1000 + 16'(2 * i + 1);
        end
        @(posedge clk);
        #1;
        quiet();
        issue_v = 1'b1; issue_rd = 3'd3;
        @(posedge clk);
        #1;
        quiet();
        ra1 = 3'd1; ra2 = 3'd3;
        #1;
        check("pre.rd1", rd1, 16'h1001);
        check("pre.busy2", {15'd0, busy2}, 16'd1);
        @(posedge clk);
        #1;
        clear_req = 1'b1; ra1 = 3'd7;
        #1;
        check("pre.rd1_r7", rd1, 16'h1007);
        check("pre.clr_busy", {15'd0, clr_busy}, 16'd0);

        count = 0;
        @(posedge clk);
        #1;
        clear_req = 1'b0;
        we0 = 1'b1; wa0 = 3'd1; wd0 = 16'hFFFF;
        we1 = 1'b1; wa1 = 3'd1; wd1 = 16'hEEEE;
        issue_v = 1'b1; issue_rd = 3'd5;
        ra1 = 3'd1; ra2 = 3'd3;
        @(negedge clk);
        if (clr_busy) count++;
        check("sweep.raw_rd1", rd1, 16'h1001);
        check("sweep.busy2_wiped", {15'd0, busy2}, 16'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        if (clr_busy) count++;
        check("sweep.no_collide", {15'd0, wcollide}, 16'd0);
        @(posedge clk);
        #1;
        quiet();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!clr_busy) break;
            count++;
        end
        check("sweep.cycles", 16'(count), 16'd8);
        for (int a = 0; a < 8; a++) begin
            ra1 = 3'(a); ra2 = 3'(a);
            #1;
            check($sformatf("post.rd1_r%0d", a), rd1, 16'h0000);
            check($sformatf("post.busy2_r%0d", a), {15'd0, busy2}, 16'd0);
        end

        // Reset in the third sweep cycle.
        @(posedge clk);
        #1;
        we0 = 1'b1; wa0 = 3'd5; wd0 = 16'h5555;
        @(posedge clk);
        #1;
        quiet();
        clear_req = 1'b1;
        @(posedge clk);
        #1;
        clear_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst.sweep_running", {15'd0, clr_busy}, 16'd1);
        reset = 1'b1;
        #1;
        check("rst.clr_busy", {15'd0, clr_busy}, 16'd0);
        for (int a = 0; a < 8; a++) begin
            ra1 = 3'(a);
            #1;
            check($sformatf("rst.rd1_r%0d", a), rd1, 16'h0000);
        end
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        we0 = 1'b1; wa0 = 3'd5; wd0 = 16'h0ABC;
        @(posedge clk);
        #1;
        quiet();
        ra1 = 3'd5;
        #1;
        check("rst.write_after", rd1, 16'h0ABC);
        check("rst.still_idle", {15'd0, clr_busy}, 16'd0);

`ifdef REGFILE_R0_ZERO_EN
        // Hardwired zero register.
        @(posedge clk);
        #1;
        we0 = 1'b1; wa0 = 3'd0; wd0 = 16'hFFFF;
        we1 = 1'b1; wa1 = 3'd0; wd1 = 16'h1111;
        issue_v = 1'b1; issue_rd = 3'd0;
        ra1 = 3'd0;
        #1;
        check("r0.rd1_same", rd1, 16'h0000);
        check("r0.busy1_same", {15'd0, busy1}, 16'd0);
        @(posedge clk);
        #1;
        quiet();
        #1;
        check("r0.rd1_next", rd1, 16'h0000);
        check("r0.busy1_next", {15'd0, busy1}, 16'd0);
        check("r0.no_collide", {15'd0, wcollide}, 16'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
